sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller_pkg.sv | 19 +
 rtl/sram_wait_counter.sv | 41 ++++
 rtl/sram_controller.sv | 139 +++++++++++++
 tb/tb_sram_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the 32-bit CPU to 16-bit async SRAM bridge.
// Holds bus widths, the default CPU base address and the access FSM states.
// Purely declarative: no logic, no latency.
package sram_controller_pkg;

    localparam int SRAM_DATA_W       = 16;
    localparam int SRAM_ADDR_W       = 18;
    localparam int DEFAULT_ADDR_BASE = 1024;
    // Wide enough for WAIT_CYCLES up to 15
    localparam int WAIT_CNT_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } sram_state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter timing one half-word SRAM phase.
// Latency: tc_o asserts on the WAIT_CYCLES-th enabled cycle after a clear.
// Backpressure: none; clear has priority over enable.
module sram_wait_counter
    import sram_controller_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(WAIT_CYCLES - 1);

    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear on phase entry, otherwise advance while the phase runs
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/sram_controller.sv
// Bridges a 32-bit CPU load/store to a 16-bit SRAM as two half-word phases.
// Latency: 1 + 2*WAIT_CYCLES stall cycles, read_data valid in the DONE cycle.
// Backpressure: ready low while a request is pending or in flight; pipeline freezes on ~ready.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter int unsigned ADDR_BASE   = DEFAULT_ADDR_BASE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N
);

    // Only the low 19 bits of the offset matter; the rest are overflow and dropped
    localparam logic [18:0] BASE_LO = 19'(ADDR_BASE);

    sram_state_t              state_q, state_d;
    logic                     op_wr_q, op_wr_d;
    logic [SRAM_ADDR_W-2:0]   waddr_q, waddr_d;
    logic [31:0]              data_q, data_d;
    logic [31:0]              read_data_q, read_data_d;

    logic                     req;
    logic [18:0]              addr_off;
    logic                     cnt_clr, cnt_en, cnt_tc;
    logic                     dq_oe;
    logic [SRAM_DATA_W-1:0]   dq_out;
    logic                     unused_addr_bits;

    assign req              = wr_en | rd_en;
    assign addr_off         = address[18:0] - BASE_LO;
    assign unused_addr_bits = ^{address[31:19], addr_off[1:0]};

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    // FSM next state, request latching and read-data capture at phase ends
    always_comb begin
        state_d     = state_q;
        op_wr_d     = op_wr_q;
        waddr_d     = waddr_q;
        data_d      = data_q;
        read_data_d = read_data_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    // Store wins when both requests are raised together
                    op_wr_d = wr_en;
                    waddr_d = addr_off[18:2];
                    data_d  = write_data;
                    cnt_clr = 1'b1;
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    if (!op_wr_q) begin
                        read_data_d[15:0] = SRAM_DQ;
                    end
                    cnt_clr = 1'b1;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    if (!op_wr_q) begin
                        read_data_d[31:16] = SRAM_DQ;
                    end
                    cnt_clr = 1'b1;
                    state_d = ST_DONE;
                end
            end
            // One-cycle completion; a still-held request is only taken again from IDLE
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_wr_q     <= 1'b0;
            waddr_q     <= '0;
            data_q      <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            op_wr_q     <= op_wr_d;
            waddr_q     <= waddr_d;
            data_q      <= data_d;
            read_data_q <= read_data_d;
        end
    end

    // SRAM pin decode from the current phase and the latched operation
    always_comb begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;
        if (state_q == ST_LOW || state_q == ST_HIGH) begin
            SRAM_ADDR = {waddr_q, (state_q == ST_HIGH)};
            if (op_wr_q) begin
                SRAM_WE_N = 1'b0;
                dq_oe     = 1'b1;
                dq_out    = (state_q == ST_HIGH) ? data_q[31:16] : data_q[15:0];
            end else begin
                SRAM_OE_N = 1'b0;
            end
        end
    end

    assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DATA_W{1'bz}};
    assign read_data = read_data_q;
    assign ready     = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural async SRAM model.
// Each scenario task drives its own stimulus and checks against hand-computed values.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N, SRAM_OE_N;

    int tests = 0;
    int fails = 0;

    logic [15:0] mem [0:262143];

    always #5 clk = ~clk;

    sram_controller #(
        .WAIT_CYCLES (2),
        .ADDR_BASE   (1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (SRAM_DQ),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_OE_N  (SRAM_OE_N)
    );

    // SRAM model: drives the bus while output-enabled, stores on each write-enabled edge
    assign SRAM_DQ = (!SRAM_OE_N) ? mem[SRAM_ADDR] : 16'bz;
    always @(posedge clk) begin
        if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;
    end

    // Caller has just set the request; walks the access until ready, tallying strobes
    task automatic run_access(input int drop_after, output int stall, output int we_lo,
                              output int oe_lo, output bit done_ok,
                              output logic [17:0] first_a, output logic [17:0] last_a);
        bit seen;
        seen = 0; stall = 0; we_lo = 0; oe_lo = 0; done_ok = 0;
        first_a = '0; last_a = '0;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (ready) begin
                done_ok = 1;
                break;
            end
            stall++;
            @(negedge clk);
            if (c + 1 == drop_after) begin
                wr_en = 0; rd_en = 0;
                address = 32'hFFFF_FFF0; write_data = 32'h0BAD_0BAD;
            end
            #1;
            if (!SRAM_WE_N) we_lo++;
            if (!SRAM_OE_N) oe_lo++;
            if (!SRAM_WE_N || !SRAM_OE_N) begin
                if (!seen) first_a = SRAM_ADDR;
                seen = 1;
                last_a = SRAM_ADDR;
            end
        end
    endtask

    task automatic test_reset();
        rst = 0; wr_en = 0; rd_en = 0; address = 0; write_data = 0;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
        tests++; if (SRAM_WE_N !== 1'b1) begin fails++; $display("FAIL reset_we_n got %b want 1", SRAM_WE_N); end
        tests++; if (SRAM_OE_N !== 1'b1) begin fails++; $display("FAIL reset_oe_n got %b want 1", SRAM_OE_N); end
        tests++; if (SRAM_ADDR !== 18'd0) begin fails++; $display("FAIL reset_addr got %0d want 0", SRAM_ADDR); end
        tests++; if (read_data !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", read_data); end
        rst = 1;
    endtask

    task automatic test_write();
        int st, we, oe; bit ok; logic [17:0] fa, la;
        @(negedge clk);
        wr_en = 1; rd_en = 0; address = 32'd1032; write_data = 32'hDEAD_BEEF;
        #1;
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL wr_req_ready got %b want 0", ready); end
        run_access(0, st, we, oe, ok, fa, la);
        tests++; if (!ok) begin fails++; $display("FAIL wr_timeout got 0 want 1"); end
        tests++; if (st != 5) begin fails++; $display("FAIL wr_stall got %0d want 5", st); end
        tests++; if (we != 4) begin fails++; $display("FAIL wr_we_cycles got %0d want 4", we); end
        tests++; if (oe != 0) begin fails++; $display("FAIL wr_oe_cycles got %0d want 0", oe); end
        tests++; if (fa !== 18'd4 || la !== 18'd5) begin fails++; $display("FAIL wr_addrs got %0d/%0d want 4/5", fa, la); end
        tests++; if (mem[4] !== 16'hBEEF) begin fails++; $display("FAIL wr_mem4 got %h want beef", mem[4]); end
        tests++; if (mem[5] !== 16'hDEAD) begin fails++; $display("FAIL wr_mem5 got %h want dead", mem[5]); end
        wr_en = 0; address = 0; write_data = 0;
        @(negedge clk); #1;
        tests++; if (ready !== 1'b1 || SRAM_WE_N !== 1'b1) begin fails++; $display("FAIL wr_after_done ready=%b we_n=%b want 1/1", ready, SRAM_WE_N); end
    endtask

    task automatic test_read();
        int st, we, oe; bit ok; logic [17:0] fa, la;
        @(negedge clk);
        rd_en = 1; wr_en = 0; address = 32'd1032;
        run_access(0, st, we, oe, ok, fa, la);
        tests++; if (!ok || st != 5) begin fails++; $display("FAIL rd_stall got %0d ok=%b want 5", st, ok); end
        tests++; if (oe != 4) begin fails++; $display("FAIL rd_oe_cycles got %0d want 4", oe); end
        tests++; if (we != 0) begin fails++; $display("FAIL rd_we_cycles got %0d want 0", we); end
        tests++; if (fa !== 18'd4 || la !== 18'd5) begin fails++; $display("FAIL rd_addrs got %0d/%0d want 4/5", fa, la); end
        tests++; if (read_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data got %h want deadbeef", read_data); end
        rd_en = 0; address = 0;
    endtask

    task automatic test_both();
        int st, we, oe; bit ok; logic [17:0] fa, la;
        @(negedge clk);
        wr_en = 1; rd_en = 1; address = 32'd1024; write_data = 32'h1234_5678;
        run_access(0, st, we, oe, ok, fa, la);
        tests++; if (!ok || st != 5) begin fails++; $display("FAIL both_stall got %0d ok=%b want 5", st, ok); end
        tests++; if (we != 4 || oe != 0) begin fails++; $display("FAIL both_strobes we=%0d oe=%0d want 4/0", we, oe); end
        tests++; if (mem[0] !== 16'h5678 || mem[1] !== 16'h1234) begin fails++; $display("FAIL both_mem got %h/%h want 5678/1234", mem[0], mem[1]); end
        tests++; if (read_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL both_rdata got %h want deadbeef", read_data); end
        wr_en = 0; rd_en = 0; address = 0; write_data = 0;
    endtask

    task automatic test_back_to_back();
        int st, we, oe; bit ok; logic [17:0] fa, la;
        @(negedge clk);
        wr_en = 1; address = 32'd1028; write_data = 32'hBABE_CAFE;
        run_access(0, st, we, oe, ok, fa, la);
        wr_en = 0; write_data = 0;
        @(negedge clk);
        rd_en = 1; address = 32'd1024;
        run_access(0, st, we, oe, ok, fa, la);
        tests++; if (!ok || st != 5) begin fails++; $display("FAIL b2b_stall1 got %0d ok=%b want 5", st, ok); end
        tests++; if (read_data !== 32'h1234_5678) begin fails++; $display("FAIL b2b_rdata1 got %h want 12345678", read_data); end
        address = 32'd1028;
        @(negedge clk); #1;
        tests++; if (ready !== 1'b0 || SRAM_OE_N !== 1'b1) begin fails++; $display("FAIL b2b_idle_gap ready=%b oe_n=%b want 0/1", ready, SRAM_OE_N); end
        run_access(0, st, we, oe, ok, fa, la);
        tests++; if (!ok || st != 5) begin fails++; $display("FAIL b2b_stall2 got %0d ok=%b want 5", st, ok); end
        tests++; if (oe != 4) begin fails++; $display("FAIL b2b_oe2 got %0d want 4", oe); end
        tests++; if (fa !== 18'd2 || la !== 18'd3) begin fails++; $display("FAIL b2b_addrs got %0d/%0d want 2/3", fa, la); end
        tests++; if (read_data !== 32'hBABE_CAFE) begin fails++; $display("FAIL b2b_rdata2 got %h want babecafe", read_data); end
        rd_en = 0; address = 0;
        @(negedge clk); #1;
        tests++; if (ready !== 1'b1 || SRAM_OE_N !== 1'b1) begin fails++; $display("FAIL b2b_end ready=%b oe_n=%b want 1/1", ready, SRAM_OE_N); end
    endtask

    task automatic test_drop();
        int st, we, oe; bit ok; logic [17:0] fa, la;
        @(negedge clk);
        rd_en = 1; address = 32'd1032;
        run_access(1, st, we, oe, ok, fa, la);
        tests++; if (!ok || st != 5) begin fails++; $display("FAIL drop_stall got %0d ok=%b want 5", st, ok); end
        tests++; if (oe != 4) begin fails++; $display("FAIL drop_oe got %0d want 4", oe); end
        tests++; if (fa !== 18'd4 || la !== 18'd5) begin fails++; $display("FAIL drop_addrs got %0d/%0d want 4/5", fa, la); end
        tests++; if (read_data !== 32'hDEAD_BEEF || ready !== 1'b1) begin fails++; $display("FAIL drop_done rdata=%h ready=%b want deadbeef/1", read_data, ready); end
        address = 0; write_data = 0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        wr_en = 1; address = 32'd1040; write_data = 32'h1111_2222;
        repeat (4) @(negedge clk);
        #1;
        tests++; if (SRAM_ADDR !== 18'd9 || SRAM_WE_N !== 1'b0) begin fails++; $display("FAIL rstmid_high addr=%0d we_n=%b want 9/0", SRAM_ADDR, SRAM_WE_N); end
        rst = 0; wr_en = 0;
        @(negedge clk); #1;
        tests++; if (SRAM_WE_N !== 1'b1 || SRAM_OE_N !== 1'b1) begin fails++; $display("FAIL rstmid_strobes we_n=%b oe_n=%b want 1/1", SRAM_WE_N, SRAM_OE_N); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got %b want 1", ready); end
        tests++; if (SRAM_ADDR !== 18'd0) begin fails++; $display("FAIL rstmid_addr got %0d want 0", SRAM_ADDR); end
        tests++; if (read_data !== 32'h0) begin fails++; $display("FAIL rstmid_rdata got %h want 0", read_data); end
        tests++; if (mem[8] !== 16'h2222) begin fails++; $display("FAIL rstmid_partial got %h want 2222", mem[8]); end
        rst = 1;
        @(negedge clk); #1;
        tests++; if (ready !== 1'b1 || SRAM_WE_N !== 1'b1 || read_data !== 32'h0) begin fails++; $display("FAIL rstmid_after ready=%b we_n=%b rdata=%h want 1/1/0", ready, SRAM_WE_N, read_data); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_both();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
